// File: rtl/cond_seq_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : cond_seq_unit_if
//  Purpose  : Decoder-to-datapath bundle for cond_seq_unit. Carries the
//             decoded instruction fields, the IT opener fields, the gated
//             write enables and the performance counters.
//  Modports : master - decoder/testbench side (drives instruction fields)
//             slave  - cond_seq_unit side (drives gated enables and status)
//  Revision : 1.0 - initial release
// ============================================================================
interface cond_seq_unit_if #(
  parameter int NBANKS = 2,
  parameter int PCS_W  = 2,
  parameter int CNT_W  = 16
);
  // Width 1 is kept for a single bank so the port never collapses to zero.
  localparam int BSW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

  logic             instr_valid;
  logic [BSW-1:0]   bank_sel;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic [PCS_W-1:0] PCS;
  logic             RegW;
  logic             MemW;
  logic             it_start;
  logic [3:0]       it_cond;
  logic [1:0]       it_len;
  logic [3:0]       it_then;
  logic [PCS_W-1:0] PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic             it_active;
  logic             cond_fault;
  logic [CNT_W-1:0] perf_exec;
  logic [CNT_W-1:0] perf_squash;

  modport master (
    output instr_valid, bank_sel, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
           it_start, it_cond, it_len, it_then,
    input  PCSrc, RegWrite, MemWrite, CondEx, it_active, cond_fault,
           perf_exec, perf_squash
  );

  modport slave (
    input  instr_valid, bank_sel, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
           it_start, it_cond, it_len, it_then,
    output PCSrc, RegWrite, MemWrite, CondEx, it_active, cond_fault,
           perf_exec, perf_squash
  );
endinterface
`default_nettype wire

// File: rtl/cond_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cond_seq_unit
//  Purpose  : Conditional-execution unit. Holds NBANKS banked NZCV flag
//             registers, evaluates the ARM condition of each instruction and
//             gates RegWrite/MemWrite/PCSrc/flag writes. An IT-style
//             sequencer predicates up to 4 following instructions on one base
//             condition (per slot: the condition or its inverse).
//  Ports    : clk, reset (sync, active-high) - plain scalar ports
//             bus (cond_seq_unit_if.slave)    - instruction fields in,
//                                              gated enables/status/counters out
//  Config   : CONDSEQ_PERF_EN - when defined, saturating executed/squashed
//             instruction counters drive perf_exec/perf_squash; otherwise
//             both read 0.
//  Revision : 1.0 - initial release
// ============================================================================
module cond_seq_unit #(
  parameter int NBANKS = 2,
  parameter int PCS_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  cond_seq_unit_if.slave  bus
);
  localparam int              BSW   = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam logic [BSW:0]    C_NB  = NBANKS[BSW:0];
  localparam logic [3:0]      C_NV  = 4'b1111;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic [3:0] r_it_cond, r_it_then;
  logic [1:0] r_it_len;
  logic [3:0] r_flags [NBANKS];

  logic [3:0] w_flags;
  logic [3:0] w_eff_cond;
  logic       w_condex, w_fault, w_opener, w_latch;
  logic [1:0] w_flag_wr;

  // ARM condition evaluation on {N,Z,C,V}. 1111 never executes.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = !z;
      4'b0010: cond_eval = cf;
      4'b0011: cond_eval = !cf;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = !n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = !v;
      4'b1000: cond_eval = cf && !z;
      4'b1001: cond_eval = !cf || z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = !z && (n == v);
      4'b1101: cond_eval = z || (n != v);
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  // Registered flags only: a flag write lands one cycle later.
  assign w_flags = ({1'b0, bus.bank_sel} < C_NB) ? r_flags[bus.bank_sel] : 4'b0000;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_latch     = 1'b0;
    w_opener    = 1'b0;
    w_condex    = 1'b0;
    w_fault     = 1'b0;
    w_eff_cond  = bus.Cond;
    if (!reset && bus.instr_valid) begin
      if (r_state == S_IDLE) begin
        if (bus.it_start) begin
          // The opener itself never executes; a block whose first slot is
          // an "else" slot is malformed and is not entered.
          w_opener = 1'b1;
          if (bus.it_then[0]) begin
            w_latch     = 1'b1;
            w_state_nxt = S_ACTIVE;
            w_idx_nxt   = 2'd0;
          end else begin
            w_fault = 1'b1;
          end
        end else begin
          w_fault  = (bus.Cond == C_NV);
          w_condex = cond_eval(bus.Cond, w_flags);
        end
      end else begin
        w_eff_cond = r_it_then[r_idx] ? r_it_cond : (r_it_cond ^ 4'b0001);
        // Nested opener, NV base, or inverted AL: squash the slot.
        if (bus.it_start || (r_it_cond == C_NV) || (w_eff_cond == C_NV)) begin
          w_fault = 1'b1;
        end else begin
          w_condex = cond_eval(w_eff_cond, w_flags);
        end
        w_idx_nxt = r_idx + 2'd1;
        if ((r_idx == r_it_len) || (w_condex && (bus.PCS != '0))) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 2'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= 2'd0;
      r_it_cond <= 4'b0000;
      r_it_then <= 4'b0000;
      r_it_len  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_latch) begin
        r_it_cond <= bus.it_cond;
        r_it_then <= bus.it_then;
        r_it_len  <= bus.it_len;
      end
    end
  end

  // w_condex is already zero when instr_valid is low.
  assign w_flag_wr = bus.FlagW & {2{w_condex}};

  always_ff @(posedge clk) begin
    for (int i = 0; i < NBANKS; i++) begin
      if (reset) begin
        r_flags[i] <= 4'b0000;
      end else if (bus.bank_sel == i[BSW-1:0]) begin
        if (w_flag_wr[1]) r_flags[i][3:2] <= bus.ALUFlags[3:2];
        if (w_flag_wr[0]) r_flags[i][1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  assign bus.CondEx     = w_condex;
  assign bus.RegWrite   = bus.RegW & w_condex;
  assign bus.MemWrite   = bus.MemW & w_condex;
  assign bus.PCSrc      = w_condex ? bus.PCS : '0;
  assign bus.cond_fault = w_fault;
  assign bus.it_active  = !reset && (r_state == S_ACTIVE);

`ifdef CONDSEQ_PERF_EN
  logic [CNT_W-1:0] r_exec, r_squash;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_exec   <= '0;
      r_squash <= '0;
    end else if (bus.instr_valid) begin
      if (w_condex && (r_exec != {CNT_W{1'b1}}))
        r_exec <= r_exec + 1'b1;
      if (!w_condex && !w_opener && (r_squash != {CNT_W{1'b1}}))
        r_squash <= r_squash + 1'b1;
    end
  end

  assign bus.perf_exec   = reset ? '0 : r_exec;
  assign bus.perf_squash = reset ? '0 : r_squash;
`else
  assign bus.perf_exec   = {CNT_W{1'b0}};
  assign bus.perf_squash = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_cond_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cond_seq_unit
//  Purpose  : Self-checking bench for cond_seq_unit: a directed vector table
//             for the flag/bank/IT corner cases, a counter saturation run and
//             a randomized run against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cond_seq_unit;
  localparam int NB = 2;
  localparam int PW = 2;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cond_seq_unit_if #(.NBANKS(NB), .PCS_W(PW), .CNT_W(CW)) bus ();
  cond_seq_unit #(.NBANKS(NB), .PCS_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Flags per bank, plus a queue holding the effective condition of every
  // remaining slot of the open IT block (empty queue = not in a block).
  logic [3:0] m_flags [NB];
  logic [3:0] m_q [$];
  int m_exec = 0, m_squash = 0;
  logic e_cx, e_flt, e_act, e_rw, e_mw;
  logic [1:0] e_pc;

  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    // Odd codes are the negation of the even code below them.
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: return (c == 4'b1110);
    endcase
    return base ^ c[0];
  endfunction

  task automatic model_eval();
    logic [3:0] f;
    f = m_flags[bus.bank_sel];
    e_cx = 0; e_flt = 0;
    e_act = !rst && (m_q.size() > 0);
    if (!rst && bus.instr_valid) begin
      if (m_q.size() > 0) begin
        if (bus.it_start) e_flt = 1;
        else begin
          e_flt = (m_q[0] == 4'hF);
          e_cx  = ref_pass(m_q[0], f);
        end
      end else if (bus.it_start) begin
        e_flt = !bus.it_then[0];
      end else begin
        e_flt = (bus.Cond == 4'hF);
        e_cx  = ref_pass(bus.Cond, f);
      end
    end
    e_rw = bus.RegW & e_cx;
    e_mw = bus.MemW & e_cx;
    e_pc = e_cx ? bus.PCS : 2'b00;
  endtask

  task automatic model_commit();
    logic opener;
    if (rst) begin
      for (int i = 0; i < NB; i++) m_flags[i] = 4'h0;
      m_q.delete();
      m_exec = 0; m_squash = 0;
    end else if (bus.instr_valid) begin
      opener = (m_q.size() == 0) && bus.it_start;
      if (e_cx && bus.FlagW[1]) m_flags[bus.bank_sel][3:2] = bus.ALUFlags[3:2];
      if (e_cx && bus.FlagW[0]) m_flags[bus.bank_sel][1:0] = bus.ALUFlags[1:0];
      if (e_cx) m_exec = (m_exec < 15) ? m_exec + 1 : 15;
      else if (!opener) m_squash = (m_squash < 15) ? m_squash + 1 : 15;
      if (m_q.size() > 0) begin
        void'(m_q.pop_front());
        if (e_cx && bus.PCS != 0) m_q.delete();
      end else if (bus.it_start && bus.it_then[0]) begin
        for (int k = 0; k <= int'(bus.it_len); k++)
          m_q.push_back((bus.it_cond == 4'hF) ? 4'hF :
                        (bus.it_then[k] ? bus.it_cond : bus.it_cond ^ 4'h1));
      end
    end
  endtask

  function automatic int exp_perf(input int v);
`ifdef CONDSEQ_PERF_EN
    return rst ? 0 : v;
`else
    return 0;
`endif
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic rst, v, bank;
    logic [3:0] cond, alu;
    logic [1:0] fw, pcs;
    logic rw, mw, its;
    logic [3:0] itc;
    logic [1:0] itl;
    logic [3:0] itt;
    logic x_rw, x_mw;
    logic [1:0] x_pc;
    logic x_cx, x_act, x_flt;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t V(input logic r, v, b, input logic [3:0] c, a,
                             input logic [1:0] fw, pcs, input logic rw, mw, its,
                             input logic [3:0] itc, input logic [1:0] itl,
                             input logic [3:0] itt, input logic xrw, xmw,
                             input logic [1:0] xpc, input logic xcx, xact, xflt);
    vec_t t;
    t.rst = r; t.v = v; t.bank = b; t.cond = c; t.alu = a; t.fw = fw; t.pcs = pcs;
    t.rw = rw; t.mw = mw; t.its = its; t.itc = itc; t.itl = itl; t.itt = itt;
    t.x_rw = xrw; t.x_mw = xmw; t.x_pc = xpc; t.x_cx = xcx; t.x_act = xact; t.x_flt = xflt;
    return t;
  endfunction

  task automatic drive(input logic r, v, b, input logic [3:0] c, a, input logic [1:0] fw, pcs,
                       input logic rw, mw, its, input logic [3:0] itc,
                       input logic [1:0] itl, input logic [3:0] itt);
    @(negedge clk);
    rst = r; bus.instr_valid = v; bus.bank_sel = b; bus.Cond = c; bus.ALUFlags = a;
    bus.FlagW = fw; bus.PCS = pcs; bus.RegW = rw; bus.MemW = mw; bus.it_start = its;
    bus.it_cond = itc; bus.it_len = itl; bus.it_then = itt;
    #2;
    model_eval();
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".RegWrite"}, 32'(bus.RegWrite), 32'(e_rw));
    chk({tag, ".MemWrite"}, 32'(bus.MemWrite), 32'(e_mw));
    chk({tag, ".PCSrc"}, 32'(bus.PCSrc), 32'(e_pc));
    chk({tag, ".CondEx"}, 32'(bus.CondEx), 32'(e_cx));
    chk({tag, ".it_active"}, 32'(bus.it_active), 32'(e_act));
    chk({tag, ".cond_fault"}, 32'(bus.cond_fault), 32'(e_flt));
    chk({tag, ".perf_exec"}, 32'(bus.perf_exec), 32'(exp_perf(m_exec)));
    chk({tag, ".perf_squash"}, 32'(bus.perf_squash), 32'(exp_perf(m_squash)));
  endtask

  initial begin
    // r v b cond  alu   fw    pcs  rw mw its itc   itl itt   | rw mw pc cx act flt
    tbl.push_back(V(1,1,0,4'hE,4'h0,2'b00,2'b00,1,0,0,4'h0,0,4'h0, 0,0,0,0,0,0)); // in reset
    tbl.push_back(V(0,1,0,4'h0,4'h0,2'b00,2'b00,1,0,0,4'h0,0,4'h0, 0,0,0,0,0,0)); // EQ, Z=0
    tbl.push_back(V(0,1,0,4'hE,4'h4,2'b10,2'b00,1,0,0,4'h0,0,4'h0, 1,0,0,1,0,0)); // AL, set Z b0
    tbl.push_back(V(0,1,0,4'h0,4'h0,2'b00,2'b00,1,0,0,4'h0,0,4'h0, 1,0,0,1,0,0)); // EQ b0
    tbl.push_back(V(0,1,1,4'h0,4'h0,2'b00,2'b00,1,0,0,4'h0,0,4'h0, 0,0,0,0,0,0)); // EQ b1
    tbl.push_back(V(0,1,0,4'hF,4'h0,2'b00,2'b00,1,0,0,4'h0,0,4'h0, 0,0,0,0,0,1)); // NV
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b11,2'b00,1,1,1,4'h0,2,4'h5, 0,0,0,0,0,0)); // IT opener
    tbl.push_back(V(0,1,0,4'h1,4'h0,2'b00,2'b00,1,0,0,4'h0,0,4'h0, 1,0,0,1,1,0)); // slot0 EQ
    tbl.push_back(V(0,1,0,4'h1,4'h0,2'b00,2'b00,1,0,0,4'h0,0,4'h0, 0,0,0,0,1,0)); // slot1 NE
    tbl.push_back(V(0,1,0,4'h1,4'h0,2'b00,2'b00,1,0,0,4'h0,0,4'h0, 1,0,0,1,1,0)); // slot2 EQ
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b00,0,0,0,4'h0,0,4'h0, 0,0,0,1,0,0)); // block over
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b00,0,0,1,4'hE,3,4'hF, 0,0,0,0,0,0)); // AL x4 opener
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b01,0,0,0,4'h0,0,4'h0, 0,0,1,1,1,0)); // taken branch
    tbl.push_back(V(0,1,1,4'h1,4'h0,2'b00,2'b00,1,0,0,4'h0,0,4'h0, 1,0,0,1,0,0)); // NE b1 honoured
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b00,0,0,1,4'hE,1,4'h3, 0,0,0,0,0,0)); // opener
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b00,1,0,1,4'h0,0,4'h1, 0,0,0,0,1,1)); // nested it_start
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b00,1,0,0,4'h0,0,4'h0, 1,0,0,1,1,0)); // slot1
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b00,0,0,0,4'h0,0,4'h0, 0,0,0,1,0,0)); // idle
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b00,0,0,1,4'hE,0,4'h0, 0,0,0,0,0,1)); // then[0]=0
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b00,0,0,0,4'h0,0,4'h0, 0,0,0,1,0,0)); // still idle
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b00,0,0,1,4'hE,3,4'hF, 0,0,0,0,0,0)); // opener
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b00,0,0,0,4'h0,0,4'h0, 0,0,0,1,1,0)); // slot0
    tbl.push_back(V(1,1,0,4'hE,4'h0,2'b00,2'b00,1,1,0,4'h0,0,4'h0, 0,0,0,0,0,0)); // reset mid
    tbl.push_back(V(0,1,0,4'h0,4'h0,2'b00,2'b00,1,0,0,4'h0,0,4'h0, 0,0,0,0,0,0)); // EQ, flags 0
    tbl.push_back(V(0,1,0,4'h1,4'h0,2'b00,2'b00,1,1,0,4'h0,0,4'h0, 1,1,0,1,0,0)); // NE
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b00,0,0,1,4'hE,1,4'h1, 0,0,0,0,0,0)); // AL, else slot1
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b00,0,0,0,4'h0,0,4'h0, 0,0,0,1,1,0)); // slot0
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b00,1,0,0,4'h0,0,4'h0, 0,0,0,0,1,1)); // inverted AL
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b00,0,0,0,4'h0,0,4'h0, 0,0,0,1,0,0)); // idle
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b00,0,0,1,4'h1,1,4'h3, 0,0,0,0,0,0)); // NE x2 opener
    tbl.push_back(V(0,1,0,4'hE,4'h4,2'b10,2'b00,0,0,0,4'h0,0,4'h0, 0,0,0,1,1,0)); // slot0 sets Z
    tbl.push_back(V(0,1,0,4'hE,4'h0,2'b00,2'b00,0,0,0,4'h0,0,4'h0, 0,0,0,0,1,0)); // slot1 sees Z
    tbl.push_back(V(0,0,0,4'hE,4'h0,2'b00,2'b00,1,1,0,4'h0,0,4'h0, 0,0,0,0,0,0)); // invalid
    tbl.push_back(V(0,1,0,4'h0,4'h0,2'b00,2'b00,0,0,0,4'h0,0,4'h0, 0,0,0,1,0,0)); // EQ, Z=1

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      vec_t t;
      t = tbl[i];
      tag = $sformatf("vec%0d", i);
      drive(t.rst, t.v, t.bank, t.cond, t.alu, t.fw, t.pcs, t.rw, t.mw, t.its,
            t.itc, t.itl, t.itt);
      chk({tag, ".RegWrite"}, 32'(bus.RegWrite), 32'(t.x_rw));
      chk({tag, ".MemWrite"}, 32'(bus.MemWrite), 32'(t.x_mw));
      chk({tag, ".PCSrc"}, 32'(bus.PCSrc), 32'(t.x_pc));
      chk({tag, ".CondEx"}, 32'(bus.CondEx), 32'(t.x_cx));
      chk({tag, ".it_active"}, 32'(bus.it_active), 32'(t.x_act));
      chk({tag, ".cond_fault"}, 32'(bus.cond_fault), 32'(t.x_flt));
      model_commit();
    end

    // Counter saturation: 20 executed AL instructions after reset.
    drive(1, 0, 0, 4'hE, 4'h0, 2'b00, 2'b00, 0, 0, 0, 4'h0, 0, 4'h0);
    model_commit();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, 4'hE, 4'h0, 2'b00, 2'b00, 0, 0, 0, 4'h0, 0, 4'h0);
      model_commit();
    end
    drive(0, 0, 0, 4'hE, 4'h0, 2'b00, 2'b00, 0, 0, 0, 4'h0, 0, 4'h0);
`ifdef CONDSEQ_PERF_EN
    chk("sat.perf_exec", 32'(bus.perf_exec), 32'd15);
`else
    chk("sat.perf_exec", 32'(bus.perf_exec), 32'd0);
`endif
    chk("sat.perf_squash", 32'(bus.perf_squash), 32'd0);
    model_commit();

    // Randomized run against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] itt;
      itt = 4'($urandom);
      if ($urandom_range(0, 3) != 0) itt[0] = 1'b1;
      drive(($urandom_range(0, 60) == 0), ($urandom_range(0, 4) != 0),
            1'($urandom), ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom),
            4'($urandom), 2'($urandom), ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00,
            1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom), 2'($urandom), itt);
      check_model($sformatf("rnd%0d", i));
      model_commit();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
